// File: rtl/cascaded_iir.sv
// Three cascaded Direct Form I notch sections (1.0, 2.0, 1.5 MHz) sharing one MAC, one section per clock.
// Optional: define CASCADED_IIR_SAT_EN to saturate each section result; otherwise results wrap.
module cascaded_iir #(
    parameter int DATA_WIDTH = 16,
    parameter int COEF_WIDTH = 16,
    parameter int B1_S0      = -16384,
    parameter int A1_S0      = -15360,
    parameter int A2_S0      = 14400,
    parameter int B1_S1      = 16384,
    parameter int A1_S1      = 15360,
    parameter int A2_S1      = 14400,
    parameter int B1_S2      = 0,
    parameter int A1_S2      = 0,
    parameter int A2_S2      = 14400
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic signed [DATA_WIDTH-1:0] x_in,
    output logic signed [DATA_WIDTH-1:0] x_out
);

    localparam int FRAC   = COEF_WIDTH - 2;
    localparam int PROD_W = DATA_WIDTH + COEF_WIDTH;
    localparam int ACC_W  = PROD_W + 4;

    localparam logic [1:0] PH_S0 = 2'd0;
    localparam logic [1:0] PH_S1 = 2'd1;
    localparam logic [1:0] PH_S2 = 2'd2;

    localparam logic signed [COEF_WIDTH-1:0] COEF_ONE = COEF_WIDTH'(2 ** FRAC);
    localparam logic signed [ACC_W-1:0]      RND      = ACC_W'(2 ** (FRAC - 1));

    logic [1:0]                   r_ph;
    logic signed [DATA_WIDTH-1:0] r_x1 [0:2];
    logic signed [DATA_WIDTH-1:0] r_x2 [0:2];
    logic signed [DATA_WIDTH-1:0] r_y1 [0:2];
    logic signed [DATA_WIDTH-1:0] r_y2 [0:2];
    logic signed [DATA_WIDTH-1:0] r_yPrev;

    logic signed [DATA_WIDTH-1:0] w_xs;
    logic signed [DATA_WIDTH-1:0] w_x1;
    logic signed [DATA_WIDTH-1:0] w_x2;
    logic signed [DATA_WIDTH-1:0] w_y1;
    logic signed [DATA_WIDTH-1:0] w_y2;
    logic signed [COEF_WIDTH-1:0] w_b1;
    logic signed [COEF_WIDTH-1:0] w_a1;
    logic signed [COEF_WIDTH-1:0] w_a2;
    logic signed [PROD_W-1:0]     w_pX;
    logic signed [PROD_W-1:0]     w_pB1;
    logic signed [PROD_W-1:0]     w_pX2;
    logic signed [PROD_W-1:0]     w_pA1;
    logic signed [PROD_W-1:0]     w_pA2;
    logic signed [ACC_W-1:0]      w_acc;
    logic signed [ACC_W-1:0]      w_rnd;
    logic signed [DATA_WIDTH-1:0] w_y;

    // The phase selects which section's coefficients and history feed the shared MAC.
    always_comb begin
        w_xs = '0;
        w_x1 = '0;
        w_x2 = '0;
        w_y1 = '0;
        w_y2 = '0;
        w_b1 = '0;
        w_a1 = '0;
        w_a2 = '0;
        case (r_ph)
            PH_S0: begin
                w_xs = x_in;
                w_x1 = r_x1[0];
                w_x2 = r_x2[0];
                w_y1 = r_y1[0];
                w_y2 = r_y2[0];
                w_b1 = COEF_WIDTH'(B1_S0);
                w_a1 = COEF_WIDTH'(A1_S0);
                w_a2 = COEF_WIDTH'(A2_S0);
            end
            PH_S1: begin
                w_xs = r_yPrev;
                w_x1 = r_x1[1];
                w_x2 = r_x2[1];
                w_y1 = r_y1[1];
                w_y2 = r_y2[1];
                w_b1 = COEF_WIDTH'(B1_S1);
                w_a1 = COEF_WIDTH'(A1_S1);
                w_a2 = COEF_WIDTH'(A2_S1);
            end
            PH_S2: begin
                w_xs = r_yPrev;
                w_x1 = r_x1[2];
                w_x2 = r_x2[2];
                w_y1 = r_y1[2];
                w_y2 = r_y2[2];
                w_b1 = COEF_WIDTH'(B1_S2);
                w_a1 = COEF_WIDTH'(A1_S2);
                w_a2 = COEF_WIDTH'(A2_S2);
            end
            default: ;
        endcase
    end

    assign w_pX  = PROD_W'(w_xs) * PROD_W'(COEF_ONE);
    assign w_pB1 = PROD_W'(w_x1) * PROD_W'(w_b1);
    assign w_pX2 = PROD_W'(w_x2) * PROD_W'(COEF_ONE);
    assign w_pA1 = PROD_W'(w_y1) * PROD_W'(w_a1);
    assign w_pA2 = PROD_W'(w_y2) * PROD_W'(w_a2);

    assign w_acc = ACC_W'(w_pX) + ACC_W'(w_pB1) + ACC_W'(w_pX2)
                 - ACC_W'(w_pA1) - ACC_W'(w_pA2);
    assign w_rnd = w_acc + RND;

`ifdef CASCADED_IIR_SAT_EN
    localparam logic signed [ACC_W-1:0] MAXV = ACC_W'(2 ** (DATA_WIDTH - 1) - 1);
    localparam logic signed [ACC_W-1:0] MINV = -MAXV - ACC_W'(1);

    logic signed [ACC_W-1:0] w_shr;

    assign w_shr = w_rnd >>> FRAC;

    always_comb begin
        if (w_shr > MAXV) begin
            w_y = MAXV[DATA_WIDTH-1:0];
        end else if (w_shr < MINV) begin
            w_y = MINV[DATA_WIDTH-1:0];
        end else begin
            w_y = w_shr[DATA_WIDTH-1:0];
        end
    end
`else
    assign w_y = DATA_WIDTH'(w_rnd >>> FRAC);
`endif

    // Only the section selected by the phase shifts its history; x_out updates once per sample.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ph    <= PH_S0;
            r_yPrev <= '0;
            x_out   <= '0;
            for (int s = 0; s < 3; s++) begin
                r_x1[s] <= '0;
                r_x2[s] <= '0;
                r_y1[s] <= '0;
                r_y2[s] <= '0;
            end
        end else begin
            r_ph    <= (r_ph == PH_S2) ? PH_S0 : r_ph + 2'd1;
            r_yPrev <= w_y;
            if (r_ph == PH_S2) begin
                x_out <= w_y;
            end
            for (int s = 0; s < 3; s++) begin
                if (r_ph == 2'(s)) begin
                    r_x2[s] <= r_x1[s];
                    r_x1[s] <= w_xs;
                    r_y2[s] <= r_y1[s];
                    r_y1[s] <= w_y;
                end
            end
        end
    end

endmodule

// File: tb/tb_cascaded_iir.sv
// Self-checking bench for cascaded_iir: randomized and directed samples against a per-sample
// arithmetic model of the three notch sections; honours CASCADED_IIR_SAT_EN like the design.
module tb_cascaded_iir;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic signed [15:0] x_in = '0;
    logic signed [15:0] x_out;

    int checks = 0;
    int errors = 0;

    int mB1 [3] = '{-16384, 16384, 0};
    int mA1 [3] = '{-15360, 15360, 0};
    int mA2 [3] = '{14400, 14400, 14400};
    int mx1 [3];
    int mx2 [3];
    int my1 [3];
    int my2 [3];

    always #5 clk = ~clk;

    cascaded_iir dut (
        .clk   (clk),
        .rst_n (rst_n),
        .x_in  (x_in),
        .x_out (x_out)
    );

    function automatic void modelClear();
        for (int s = 0; s < 3; s++) begin
            mx1[s] = 0;
            mx2[s] = 0;
            my1[s] = 0;
            my2[s] = 0;
        end
    endfunction

    function automatic int quantize(input longint q);
`ifdef CASCADED_IIR_SAT_EN
        if (q > 32767) return 32767;
        if (q < -32768) return -32768;
        return int'(q);
`else
        longint m;
        m = q & 64'hFFFF;
        if (m >= 32768) m = m - 65536;
        return int'(m);
`endif
    endfunction

    // One input sample through all three sections: y = x + b1*x1 + x2 - a1*y1 - a2*y2 in Q2.14.
    function automatic int modelStep(input int xIn);
        int     v;
        int     y;
        longint acc;
        v = xIn;
        for (int s = 0; s < 3; s++) begin
            acc = longint'(v) * 16384 + longint'(mB1[s]) * mx1[s] + longint'(mx2[s]) * 16384
                - longint'(mA1[s]) * my1[s] - longint'(mA2[s]) * my2[s];
            y = quantize((acc + 8192) >>> 14);
            mx2[s] = mx1[s];
            mx1[s] = v;
            my2[s] = my1[s];
            my1[s] = y;
            v = y;
        end
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one sample on the phase-0 edge with garbage on phases 1 and 2; returns x_out after each edge.
    task automatic runSample(input int x, output int hold0, output int hold1, output int got);
        x_in = 16'(x);
        tick();
        hold0 = x_out;
        x_in = 16'($urandom);
        tick();
        hold1 = x_out;
        x_in = 16'($urandom);
        tick();
        got = x_out;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        x_in  = 16'($urandom);
        tick();
        rst_n = 1'b1;
        modelClear();
    endtask

    task automatic test_reset();
        int h0, h1, got, exp, x;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            x_in = 16'($urandom);
            tick();
            checks++;
            if (x_out !== 16'sd0) begin
                errors++;
                $display("[TB] FAIL reset_hold got %0d want 0", x_out);
            end
        end
        rst_n = 1'b1;
        modelClear();
        x = $urandom_range(0, 16000) - 8000;
        exp = modelStep(x);
        runSample(x, h0, h1, got);
        checks++;
        if (h0 !== 0) begin
            errors++;
            $display("[TB] FAIL reset_first_edge got %0d want 0", h0);
        end
        checks++;
        if (h1 !== 0) begin
            errors++;
            $display("[TB] FAIL reset_second_edge got %0d want 0", h1);
        end
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL reset_first_sample got %0d want %0d", got, exp);
        end
    endtask

    task automatic test_impulse();
        int h0, h1, got, exp, prevExp;
        doReset();
        exp = modelStep(16384);
        runSample(16384, h0, h1, got);
        checks++;
        if (got !== 16384) begin
            errors++;
            $display("[TB] FAIL impulse_first got %0d want 16384", got);
        end
        prevExp = exp;
        for (int i = 0; i < 30; i++) begin
            exp = modelStep(0);
            runSample(0, h0, h1, got);
            checks++;
            if (h0 !== prevExp || h1 !== prevExp) begin
                errors++;
                $display("[TB] FAIL impulse_hold got %0d/%0d want %0d", h0, h1, prevExp);
            end
            checks++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL impulse_tail[%0d] got %0d want %0d", i, got, exp);
            end
            prevExp = exp;
        end
    endtask

    task automatic test_dc_step();
        int h0, h1, got, exp;
        doReset();
        got = 0;
        for (int i = 0; i < 300; i++) begin
            exp = modelStep(8192);
            runSample(8192, h0, h1, got);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL dc_sample[%0d] got %0d want %0d", i, got, exp);
            end
        end
        checks++;
        if (got < 9862 || got > 9870) begin
            errors++;
            $display("[TB] FAIL dc_settle got %0d want 9866+-4", got);
        end
    endtask

    task automatic test_tone(input string name, input int period);
        int tbl [$];
        int h0, h1, got, exp, x;
        case (period)
            6:       tbl = '{8192, 4096, -4096, -8192, -4096, 4096};
            3:       tbl = '{8192, -4096, -4096};
            default: tbl = '{8192, 0, -8192, 0};
        endcase
        doReset();
        for (int i = 0; i < 400; i++) begin
            x = tbl[i % period];
            exp = modelStep(x);
            runSample(x, h0, h1, got);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL %s_sample[%0d] got %0d want %0d", name, i, got, exp);
            end
            if (i >= 200) begin
                checks++;
                if (got >= 200 || got <= -200) begin
                    errors++;
                    $display("[TB] FAIL %s_reject[%0d] got %0d want |x|<200", name, i, got);
                end
            end
        end
    endtask

    task automatic test_saturation();
        int h0, h1, got, exp;
        doReset();
        got = 0;
        for (int i = 0; i < 100; i++) begin
            exp = modelStep(32767);
            runSample(32767, h0, h1, got);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL sat_sample[%0d] got %0d want %0d", i, got, exp);
            end
`ifdef CASCADED_IIR_SAT_EN
            checks++;
            if (got < 0) begin
                errors++;
                $display("[TB] FAIL sat_no_wrap[%0d] got %0d want >=0", i, got);
            end
`endif
        end
`ifdef CASCADED_IIR_SAT_EN
        checks++;
        if (got !== 32767) begin
            errors++;
            $display("[TB] FAIL sat_clamp got %0d want 32767", got);
        end
`endif
    endtask

    task automatic test_back_to_back();
        int h0, h1, got, exp, prevExp, x;
        doReset();
        prevExp = 0;
        for (int i = 0; i < 200; i++) begin
            x = $urandom_range(0, 24000) - 12000;
            exp = modelStep(x);
            runSample(x, h0, h1, got);
            checks++;
            if (h0 !== prevExp || h1 !== prevExp) begin
                errors++;
                $display("[TB] FAIL b2b_hold[%0d] got %0d/%0d want %0d", i, h0, h1, prevExp);
            end
            checks++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL b2b_sample[%0d] got %0d want %0d", i, got, exp);
            end
            prevExp = exp;
        end
    endtask

    task automatic test_midrun_reset();
        int xs [$];
        int exps [$];
        int h0, h1, got, exp;
        doReset();
        for (int i = 0; i < 40; i++) begin
            xs.push_back($urandom_range(0, 20000) - 10000);
            exps.push_back(modelStep(xs[i]));
        end
        for (int i = 0; i < 40; i++) begin
            runSample(xs[i], h0, h1, got);
            checks++;
            if (got !== exps[i]) begin
                errors++;
                $display("[TB] FAIL midrun_pre[%0d] got %0d want %0d", i, got, exps[i]);
            end
        end
        x_in = 16'($urandom);
        tick();
        rst_n = 1'b0;
        tick();
        checks++;
        if (x_out !== 16'sd0) begin
            errors++;
            $display("[TB] FAIL midrun_reset_out got %0d want 0", x_out);
        end
        rst_n = 1'b1;
        modelClear();
        for (int i = 0; i < 40; i++) begin
            exp = modelStep(xs[i]);
            runSample(xs[i], h0, h1, got);
            if (i == 0) begin
                checks++;
                if (h0 !== 0 || h1 !== 0) begin
                    errors++;
                    $display("[TB] FAIL midrun_restart_hold got %0d/%0d want 0", h0, h1);
                end
            end
            checks++;
            if (got !== exp || got !== exps[i]) begin
                errors++;
                $display("[TB] FAIL midrun_replay[%0d] got %0d want %0d", i, got, exps[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_dc_step();
        test_tone("tone1p0", 6);
        test_tone("tone2p0", 3);
        test_tone("tone1p5", 4);
        test_saturation();
        test_back_to_back();
        test_midrun_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
